// File: rtl/CacheTypes.sv
// Shared cache-port types.
//   CacheIF_t      : request presented to one cache bank arbiter input
//                    (ce active-low, we active-low write enable).
//   CacheReq_t     : queued client request {we, addr, data, wm, tag}.
//   CACHE_READ_LAT : cycles from arbiter grant to read data on the port.
package CacheTypes;

  localparam int CACHE_ADDR_WIDTH = 32;
  localparam int CACHE_DATA_WIDTH = 32;
  localparam int CACHE_TAG_WIDTH  = 4;
  localparam int CACHE_READ_LAT   = 2;

  typedef struct packed {
    logic                            ce;
    logic                            we;
    logic [CACHE_ADDR_WIDTH-1:0]     addr;
    logic [CACHE_DATA_WIDTH-1:0]     data;
    logic [CACHE_DATA_WIDTH/8-1:0]   wm;
  } CacheIF_t;

  typedef struct packed {
    logic                            we;
    logic [CACHE_ADDR_WIDTH-1:0]     addr;
    logic [CACHE_DATA_WIDTH-1:0]     data;
    logic [CACHE_DATA_WIDTH/8-1:0]   wm;
    logic [CACHE_TAG_WIDTH-1:0]      tag;
  } CacheReq_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Register FIFO of CacheReq_t entries.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i (ignored while full)
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head entry (ignored while empty)
//   head_o       : current head slot (driven even when empty)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module cache_req_fifo
  import CacheTypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  CacheReq_t push_data_i,
  input  logic      pop_i,
  output CacheReq_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  CacheReq_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if the head is popped this cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so an empty head never shows X.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/cache_port_queue.sv
// Per-client request queue in front of one cache bank arbiter port.
//   clk, rst      : clock, synchronous active-high reset
//   IN_valid / OUT_ready : client request handshake (OUT_ready = !full)
//   IN_we, IN_addr, IN_data, IN_wm, IN_tag : request fields (we: 0 = write)
//   OUT_port      : head request to arbiter (ce active-low, retried until granted)
//   IN_portReady  : same-cycle grant of the presented request
//   IN_portRData  : read data, CACHE_READ_LAT cycles after grant
//   OUT_rvalid, OUT_rdata, OUT_rtag : registered one-cycle read return
// The widths must match the CacheTypes constants that size the structs.
module cache_port_queue
  import CacheTypes::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int TAG_WIDTH  = CACHE_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_valid,
  output logic                    OUT_ready,
  input  logic                    IN_we,
  input  logic [ADDR_WIDTH-1:0]   IN_addr,
  input  logic [DATA_WIDTH-1:0]   IN_data,
  input  logic [DATA_WIDTH/8-1:0] IN_wm,
  input  logic [TAG_WIDTH-1:0]    IN_tag,
  output CacheIF_t                OUT_port,
  input  logic                    IN_portReady,
  input  logic [DATA_WIDTH-1:0]   IN_portRData,
  output logic                    OUT_rvalid,
  output logic [DATA_WIDTH-1:0]   OUT_rdata,
  output logic [TAG_WIDTH-1:0]    OUT_rtag
);

  localparam int LAT = CACHE_READ_LAT;

  CacheReq_t            push_req;
  CacheReq_t            head;
  logic                 full;
  logic                 empty;
  logic                 grant;

  logic [LAT-1:0]       trk_vld_q, trk_vld_d;
  logic [TAG_WIDTH-1:0] trk_tag_q [LAT];
  logic [TAG_WIDTH-1:0] trk_tag_d [LAT];
  logic                 rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TAG_WIDTH-1:0] rtag_q, rtag_d;

  assign push_req = '{we: IN_we, addr: IN_addr, data: IN_data, wm: IN_wm, tag: IN_tag};

  cache_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (IN_valid),
    .push_data_i(push_req),
    .pop_i      (grant),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign OUT_ready = !full;
  assign grant     = !empty && IN_portReady;

  // Head fields always come from the head slot, even when nothing is presented.
  assign OUT_port = '{ce: empty, we: head.we, addr: head.addr, data: head.data, wm: head.wm};

  // Read tracking shift pipeline and return capture.
  always_comb begin
    trk_vld_d    = trk_vld_q;
    trk_tag_d    = trk_tag_q;
    trk_vld_d[0] = grant && head.we;
    trk_tag_d[0] = head.tag;
    for (int i = 1; i < LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
    end
    rvalid_d = trk_vld_q[LAT-1];
    if (trk_vld_q[LAT-1]) begin
      rdata_d = IN_portRData;
      rtag_d  = trk_tag_q[LAT-1];
    end else begin
      rdata_d = rdata_q;
      rtag_d  = rtag_q;
    end
  end

  // Tracking and return registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        trk_tag_q[i] <= '0;
      end
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rtag_q   <= '0;
    end else begin
      trk_vld_q <= trk_vld_d;
      trk_tag_q <= trk_tag_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rtag_q    <= rtag_d;
    end
  end

  assign OUT_rvalid = rvalid_q;
  assign OUT_rdata  = rdata_q;
  assign OUT_rtag   = rtag_q;

endmodule

// File: tb/tb_cache_port_queue.sv
// Directed self-checking bench for cache_port_queue.
module tb_cache_port_queue;
  import CacheTypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_valid;
  logic        OUT_ready;
  logic        IN_we;
  logic [31:0] IN_addr;
  logic [31:0] IN_data;
  logic [3:0]  IN_wm;
  logic [3:0]  IN_tag;
  CacheIF_t    OUT_port;
  logic        IN_portReady;
  logic [31:0] IN_portRData;
  logic        OUT_rvalid;
  logic [31:0] OUT_rdata;
  logic [3:0]  OUT_rtag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base;

  always #5 clk = ~clk;

  cache_port_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_valid    (IN_valid),
    .OUT_ready   (OUT_ready),
    .IN_we       (IN_we),
    .IN_addr     (IN_addr),
    .IN_data     (IN_data),
    .IN_wm       (IN_wm),
    .IN_tag      (IN_tag),
    .OUT_port    (OUT_port),
    .IN_portReady(IN_portReady),
    .IN_portRData(IN_portRData),
    .OUT_rvalid  (OUT_rvalid),
    .OUT_rdata   (OUT_rdata),
    .OUT_rtag    (OUT_rtag)
  );

  // Arbiter read data pattern: identifies the cycle it was driven in.
  function automatic logic [31:0] rd_pat(input int c);
    return {16'hC0DE, c[15:0]};
  endfunction

  // Advance to 1 time unit after the next rising edge; cyc names that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    IN_portRData = rd_pat(cyc);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; IN_valid = 1'b0; IN_we = 1'b1; IN_addr = 32'h0; IN_data = 32'h0;
    IN_wm = 4'h0; IN_tag = 4'h0; IN_portReady = 1'b0; IN_portRData = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ce",     64'(OUT_port.ce), 64'(1));
    chk("rst_ready",  64'(OUT_ready),   64'(1));
    chk("rst_rvalid", 64'(OUT_rvalid),  64'(0));
    chk("rst_rdata",  64'(OUT_rdata),   64'(0));
    chk("rst_rtag",   64'(OUT_rtag),    64'(0));

    // Single read: push at cycle 0, grant in cycle 1, data in 3, return in 4
    IN_valid = 1'b1; IN_we = 1'b1; IN_addr = 32'h100; IN_tag = 4'd3; IN_portReady = 1'b1;
    tick();
    chk("t1_ce",   64'(OUT_port.ce),   64'(0));
    chk("t1_addr", 64'(OUT_port.addr), 64'h100);
    chk("t1_we",   64'(OUT_port.we),   64'(1));
    IN_valid = 1'b0;
    tick();
    chk("t1_rv_c2", 64'(OUT_rvalid), 64'(0));
    tick();
    IN_portRData = 32'hDEADBEEF;
    chk("t1_rv_c3", 64'(OUT_rvalid), 64'(0));
    tick();
    chk("t1_rv_c4",  64'(OUT_rvalid),  64'(1));
    chk("t1_rdata",  64'(OUT_rdata),   64'hDEADBEEF);
    chk("t1_rtag",   64'(OUT_rtag),    64'(3));
    chk("t1_ce_c4",  64'(OUT_port.ce), 64'(1));
    tick();
    chk("t1_rv_c5", 64'(OUT_rvalid), 64'(0));

    // Retry: head stays presented unchanged through a 5-cycle stall
    IN_portReady = 1'b0;
    IN_valid = 1'b1; IN_we = 1'b1; IN_addr = 32'h200; IN_data = 32'h12345678;
    IN_wm = 4'hA; IN_tag = 4'd5;
    tick();
    IN_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ce",   64'(OUT_port.ce),   64'(0));
      chk("t2_we",   64'(OUT_port.we),   64'(1));
      chk("t2_addr", 64'(OUT_port.addr), 64'h200);
      chk("t2_data", 64'(OUT_port.data), 64'h12345678);
      chk("t2_wm",   64'(OUT_port.wm),   64'hA);
      chk("t2_rv",   64'(OUT_rvalid),    64'(0));
      tick();
    end
    IN_portReady = 1'b1;
    base = cyc;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t2_rv_after", 64'(OUT_rvalid), 64'(i == 3));
      if (i == 3) begin
        chk("t2_rtag",  64'(OUT_rtag),  64'(5));
        chk("t2_rdata", 64'(OUT_rdata), 64'(rd_pat(base + 2)));
      end
    end

    // Fill to full, ignored fifth push, then drain in push order
    IN_portReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IN_valid = 1'b1; IN_we = 1'b1; IN_addr = 32'h300 + i; IN_tag = 4'(8 + i);
      tick();
      chk("t3_ready_fill", 64'(OUT_ready), 64'(i < 3));
    end
    IN_addr = 32'h3FF; IN_tag = 4'hF;
    tick();
    chk("t3_ready_full", 64'(OUT_ready), 64'(0));
    IN_valid = 1'b0;
    IN_portReady = 1'b1;
    base = cyc;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        chk("t3_addr", 64'(OUT_port.addr), 64'(32'h300 + i));
      end
      chk("t3_rv", 64'(OUT_rvalid), 64'(i >= 3));
      if (i >= 3) begin
        chk("t3_rtag",  64'(OUT_rtag),  64'(8 + i - 3));
        chk("t3_rdata", 64'(OUT_rdata), 64'(rd_pat(base + i - 1)));
      end
      tick();
    end
    chk("t3_rv_end", 64'(OUT_rvalid),  64'(0));
    chk("t3_ce_end", 64'(OUT_port.ce), 64'(1));

    // Mixed write/read/write/read at full rate; returns only for reads
    IN_portReady = 1'b1;
    base = cyc;
    for (int i = 0; i < 9; i++) begin
      if (i >= 1 && i <= 4) begin
        chk("t4_ce",   64'(OUT_port.ce),   64'(0));
        chk("t4_we",   64'(OUT_port.we),   64'((i - 1) % 2));
        chk("t4_addr", 64'(OUT_port.addr), 64'(32'h400 + i - 1));
        chk("t4_data", 64'(OUT_port.data), 64'(32'hA0 + i - 1));
      end
      chk("t4_rv", 64'(OUT_rvalid), 64'(i == 5 || i == 7));
      if (i == 5) begin
        chk("t4_rtag2",  64'(OUT_rtag),  64'(2));
        chk("t4_rdata2", 64'(OUT_rdata), 64'(rd_pat(base + 4)));
      end
      if (i == 7) begin
        chk("t4_rtag4",  64'(OUT_rtag),  64'(4));
        chk("t4_rdata4", 64'(OUT_rdata), 64'(rd_pat(base + 6)));
      end
      IN_valid = (i < 4);
      IN_we    = (i % 2 == 1);
      IN_addr  = 32'h400 + i;
      IN_data  = 32'hA0 + i;
      IN_wm    = 4'h3;
      IN_tag   = 4'(i + 1);
      tick();
    end
    IN_valid = 1'b0;

    // Push/pop at count 2, streaming 3*DEPTH reads across pointer wrap
    IN_portReady = 1'b0;
    base = cyc;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2 && i <= 12) begin
        chk("t5_count", 64'(dut.u_fifo.count_q), 64'(2));
      end
      if (i >= 2 && i <= 13) begin
        chk("t5_addr", 64'(OUT_port.addr), 64'(32'h500 + i - 2));
      end
      chk("t5_rv", 64'(OUT_rvalid), 64'(i >= 5 && i <= 16));
      if (i >= 5 && i <= 16) begin
        chk("t5_rtag",  64'(OUT_rtag),  64'(i - 5));
        chk("t5_rdata", 64'(OUT_rdata), 64'(rd_pat(base + i - 1)));
      end
      IN_valid     = (i < 12);
      IN_we        = 1'b1;
      IN_addr      = 32'h500 + i;
      IN_tag       = 4'(i);
      IN_portReady = (i >= 2);
      tick();
    end
    IN_valid = 1'b0;
    chk("t5_rv_end", 64'(OUT_rvalid), 64'(0));
    chk("t5_ce_end", 64'(OUT_port.ce), 64'(1));

    // Reset in the cycle after a read grant drops the in-flight read
    IN_portReady = 1'b0;
    IN_valid = 1'b1; IN_we = 1'b1; IN_addr = 32'h600; IN_tag = 4'd7;
    tick();
    IN_addr = 32'h604; IN_tag = 4'd6;
    tick();
    IN_valid = 1'b0;
    IN_portReady = 1'b1;
    chk("t6_addr", 64'(OUT_port.addr), 64'h600);
    tick();
    IN_portReady = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ce",    64'(OUT_port.ce),          64'(1));
    chk("t6_ready", 64'(OUT_ready),            64'(1));
    chk("t6_count", 64'(dut.u_fifo.count_q),   64'(0));
    chk("t6_rv0",   64'(OUT_rvalid),           64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_rv", 64'(OUT_rvalid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
